// File: rtl/banked_register_file.sv
// Banked register file with two registered read ports, a debug mirror port and
// a per-register busy scoreboard that is set by reserves and cleared by writebacks.
module banked_register_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int DBG_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic              enableWrite,
  input  logic [DATA_W-1:0] BusW,
  input  logic              rsvEn,
  input  logic [ADDR_W-1:0] rsvAddr,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  output logic              busyA,
  output logic              busyB,
  output logic [DATA_W-1:0] DbgOut,
  output logic              wbOrphan
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs, regs_next;
  logic [NUM_REGS-1:0]             busy, busy_next;
  logic                            wr_hit, rsv_hit;

  assign wr_hit  = enableWrite && (RW != '0);
  assign rsv_hit = rsvEn && (rsvAddr != '0);

  // Post-edge state; reads take it so same-edge writes forward and a
  // same-index reserve overrides the write's busy clear.
  always_comb begin
    regs_next = regs;
    busy_next = busy;
    if (wr_hit) begin
      regs_next[RW] = BusW;
      busy_next[RW] = 1'b0;
    end
    if (rsv_hit) busy_next[rsvAddr] = 1'b1;
    regs_next[0] = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '0;
      busy     <= '0;
      BusA     <= '0;
      BusB     <= '0;
      DbgOut   <= '0;
      busyA    <= 1'b0;
      busyB    <= 1'b0;
      wbOrphan <= 1'b0;
    end else begin
      regs     <= regs_next;
      busy     <= busy_next;
      BusA     <= regs_next[RA];
      BusB     <= regs_next[RB];
      DbgOut   <= regs_next[DBG_IDX];
      busyA    <= busy_next[RA];
      busyB    <= busy_next[RB];
      wbOrphan <= wr_hit && !busy[RW];
    end
  end
endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench: a 16-bit/8-reg and a 32-bit/16-reg instance share stimulus;
// each check compares both instances against the same hand-computed value.
module tb_banked_register_file;
  logic        clk = 1'b0;
  logic        reset, en, rsv;
  logic [3:0]  ra, rb, rw, radr;
  logic [31:0] busw;
  logic [15:0] a0, b0, d0;
  logic [31:0] a1, b1, d1;
  logic        ya0, yb0, o0, ya1, yb1, o1;
  logic [31:0] e;
  logic        eb;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  banked_register_file #(.DATA_W(16), .ADDR_W(3), .DBG_REG(7)) dut0 (
    .clk(clk), .reset(reset), .RA(ra[2:0]), .RB(rb[2:0]), .RW(rw[2:0]),
    .enableWrite(en), .BusW(busw[15:0]), .rsvEn(rsv), .rsvAddr(radr[2:0]),
    .BusA(a0), .BusB(b0), .busyA(ya0), .busyB(yb0), .DbgOut(d0), .wbOrphan(o0));

  banked_register_file #(.DATA_W(32), .ADDR_W(4), .DBG_REG(15)) dut1 (
    .clk(clk), .reset(reset), .RA(ra), .RB(rb), .RW(rw),
    .enableWrite(en), .BusW(busw), .rsvEn(rsv), .rsvAddr(radr),
    .BusA(a1), .BusB(b1), .busyA(ya1), .busyB(yb1), .DbgOut(d1), .wbOrphan(o1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; rsv = 1'b0; rw = '0; radr = '0; busw = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); ra = 4'd3; rb = 4'd7;
    step(); step();
    e = 32'h0;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL rst_busa got %h/%h want %h", a0, a1, e); end
    reset = 1'b0;
    step();
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL init_busa got %h/%h want %h", a0, a1, e); end
    n_cmp++; if ({b0, b1} !== {e[15:0], e}) begin n_err++; $display("FAIL init_busb got %h/%h want %h", b0, b1, e); end
    n_cmp++; if ({d0, d1} !== {e[15:0], e}) begin n_err++; $display("FAIL init_dbg got %h/%h want %h", d0, d1, e); end
    n_cmp++; if ({ya0, ya1, yb0, yb1, o0, o1} !== 6'b0) begin n_err++; $display("FAIL init_flags got %b%b%b%b%b%b want 000000", ya0, ya1, yb0, yb1, o0, o1); end
  endtask

  task automatic test_write_read();
    en = 1'b1; rw = 4'd5; busw = 32'h5A5A00A5;
    step();
    eb = 1'b1;  // reg5 was never reserved
    n_cmp++; if ({o0, o1} !== {2{eb}}) begin n_err++; $display("FAIL orphan_w5 got %b%b want %b", o0, o1, eb); end
    rw = 4'd0; busw = 32'hFFFFFFFF;
    step();
    eb = 1'b0;
    n_cmp++; if ({o0, o1} !== {2{eb}}) begin n_err++; $display("FAIL orphan_w0 got %b%b want %b", o0, o1, eb); end
    idle(); ra = 4'd5; rb = 4'd0;
    step();
    e = 32'h5A5A00A5;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL rd_reg5 got %h/%h want %h", a0, a1, e); end
    e = 32'h0;
    n_cmp++; if ({b0, b1} !== {e[15:0], e}) begin n_err++; $display("FAIL rd_reg0 got %h/%h want %h", b0, b1, e); end
  endtask

  task automatic test_forward();
    en = 1'b1; rw = 4'd2; busw = 32'h11111111; ra = 4'd0;
    step();
    busw = 32'h22222222; ra = 4'd2;
    step();
    e = 32'h22222222;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL fwd_busa got %h/%h want %h", a0, a1, e); end
    idle();
    step();
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL hold_busa got %h/%h want %h", a0, a1, e); end
    // rw=15 lands on reg7 of the 3-bit-index instance: the debug register of both
    en = 1'b1; rw = 4'd15; busw = 32'hDB6000F7;
    step();
    e = 32'hDB6000F7;
    n_cmp++; if ({d0, d1} !== {e[15:0], e}) begin n_err++; $display("FAIL fwd_dbg got %h/%h want %h", d0, d1, e); end
    idle();
    step();
    n_cmp++; if ({d0, d1} !== {e[15:0], e}) begin n_err++; $display("FAIL hold_dbg got %h/%h want %h", d0, d1, e); end
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; radr = 4'd4; ra = 4'd4;
    step();
    eb = 1'b1;
    n_cmp++; if ({ya0, ya1} !== {2{eb}}) begin n_err++; $display("FAIL rsv_busya got %b%b want %b", ya0, ya1, eb); end
    idle();
    step();
    n_cmp++; if ({ya0, ya1} !== {2{eb}}) begin n_err++; $display("FAIL rsv_hold got %b%b want %b", ya0, ya1, eb); end
    en = 1'b1; rw = 4'd4; busw = 32'hCAFE0044;
    step();
    eb = 1'b0;
    n_cmp++; if ({ya0, ya1} !== {2{eb}}) begin n_err++; $display("FAIL wb_busya got %b%b want %b", ya0, ya1, eb); end
    n_cmp++; if ({o0, o1} !== {2{eb}}) begin n_err++; $display("FAIL wb_orphan got %b%b want %b", o0, o1, eb); end
    step();
    eb = 1'b1;
    n_cmp++; if ({o0, o1} !== {2{eb}}) begin n_err++; $display("FAIL wb2_orphan got %b%b want %b", o0, o1, eb); end
    idle();
    step();
    eb = 1'b0;
    n_cmp++; if ({o0, o1} !== {2{eb}}) begin n_err++; $display("FAIL orphan_pulse got %b%b want %b", o0, o1, eb); end
    e = 32'hCAFE0044;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL rd_reg4 got %h/%h want %h", a0, a1, e); end
  endtask

  task automatic test_collision();
    rsv = 1'b1; radr = 4'd6;
    step();
    en = 1'b1; rw = 4'd6; busw = 32'h60000006; ra = 4'd6; rb = 4'd6;
    step();
    e = 32'h60000006; eb = 1'b1;
    n_cmp++; if ({a0, a1, b0, b1} !== {e[15:0], e, e[15:0], e}) begin n_err++; $display("FAIL col_data got %h/%h %h/%h want %h", a0, a1, b0, b1, e); end
    n_cmp++; if ({ya0, ya1, yb0, yb1} !== {4{eb}}) begin n_err++; $display("FAIL col_busy got %b%b%b%b want %b", ya0, ya1, yb0, yb1, eb); end
    n_cmp++; if ({o0, o1} !== 2'b00) begin n_err++; $display("FAIL col_orphan got %b%b want 0", o0, o1); end
    idle();
    step();
    n_cmp++; if ({ya0, ya1} !== {2{eb}}) begin n_err++; $display("FAIL col_hold got %b%b want %b", ya0, ya1, eb); end
    rsv = 1'b1; radr = 4'd3; en = 1'b1; rw = 4'd5; busw = 32'h55550005; ra = 4'd3; rb = 4'd5;
    step();
    n_cmp++; if ({ya0, ya1, yb0, yb1} !== 4'b1100) begin n_err++; $display("FAIL indep_busy got %b%b%b%b want 1100", ya0, ya1, yb0, yb1); end
    e = 32'h55550005;
    n_cmp++; if ({b0, b1} !== {e[15:0], e}) begin n_err++; $display("FAIL indep_busb got %h/%h want %h", b0, b1, e); end
    n_cmp++; if ({o0, o1} !== 2'b11) begin n_err++; $display("FAIL indep_orphan got %b%b want 11", o0, o1); end
    idle(); rsv = 1'b1; radr = 4'd0; ra = 4'd0;
    step();
    n_cmp++; if ({ya0, ya1} !== 2'b00) begin n_err++; $display("FAIL rsv0_busy got %b%b want 00", ya0, ya1); end
  endtask

  task automatic test_reset_collision();
    reset = 1'b1; en = 1'b1; rw = 4'd1; busw = 32'h0000BEEF; rsv = 1'b1; radr = 4'd1;
    ra = 4'd1; rb = 4'd6;
    step();
    n_cmp++; if ({a0, a1, ya0, ya1, o0, o1} !== 52'h0) begin n_err++; $display("FAIL rstcol_out got %h/%h %b%b%b%b want 0", a0, a1, ya0, ya1, o0, o1); end
    reset = 1'b0; idle();
    step();
    e = 32'h0;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL rstcol_reg1 got %h/%h want %h", a0, a1, e); end
    n_cmp++; if ({ya0, ya1, yb0, yb1} !== 4'b0000) begin n_err++; $display("FAIL rstcol_busy got %b%b%b%b want 0000", ya0, ya1, yb0, yb1); end
    rb = 4'd4;
    step();
    n_cmp++; if ({b0, b1} !== {e[15:0], e}) begin n_err++; $display("FAIL rst_clr_reg4 got %h/%h want %h", b0, b1, e); end
    en = 1'b1; rw = 4'd1; busw = 32'h1234BEEF;
    step();
    e = 32'h1234BEEF;
    n_cmp++; if ({a0, a1} !== {e[15:0], e}) begin n_err++; $display("FAIL post_rst_fwd got %h/%h want %h", a0, a1, e); end
    n_cmp++; if ({o0, o1} !== 2'b11) begin n_err++; $display("FAIL post_rst_orphan got %b%b want 11", o0, o1); end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ra = '0; rb = '0; idle();
    test_reset();
    test_write_read();
    test_forward();
    test_scoreboard();
    test_collision();
    test_reset_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
